// File: rtl/mem_ctrl_if.sv
// Bundle of the core-side request/response channels and the byte-wide RAM/IO bus.
// The controller takes the slave view; the core and memory models take the master view.
interface mem_ctrl_if;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic        inst_ready;
    logic [31:0] inst_res;
    logic        data_valid;
    logic        data_wr;
    logic [2:0]  data_type;
    logic [31:0] data_addr;
    logic [31:0] data_value;
    logic        data_ready;
    logic [31:0] data_res;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  inst_valid, inst_addr, data_valid, data_wr, data_type, data_addr, data_value,
        input  mem_din, io_buffer_full,
        output inst_ready, inst_res, data_ready, data_res, mem_dout, mem_a, mem_wr
    );

    modport master (
        output inst_valid, inst_addr, data_valid, data_wr, data_type, data_addr, data_value,
        output mem_din, io_buffer_full,
        input  inst_ready, inst_res, data_ready, data_res, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests onto the
// 8-bit RAM/IO bus, issuing one byte beat per cycle and reassembling read words.
//
// state   | meaning
// S_IDLE  | bus quiet, accepting a request (data beats fetch)
// S_INST  | fetching a 4-byte instruction word
// S_LOAD  | reading 1/2/4 bytes for a load
// S_STORE | writing 1/2/4 bytes, IO beats throttled by buffer-full and gap timer
module mem_ctrl #(
    parameter int ADDR_BITS = 18,
    parameter int IO_GAP    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       clear,
    mem_ctrl_if.slave  bus
);
    localparam logic [31:0] ADDR_MASK = (ADDR_BITS >= 32) ? 32'hFFFF_FFFF
                                        : ((32'd1 << ADDR_BITS) - 32'd1);
    localparam logic [7:0]  GAP_LOAD  = (IO_GAP > 1) ? 8'(IO_GAP - 1) : 8'd0;

    typedef enum logic [1:0] {S_IDLE, S_INST, S_LOAD, S_STORE} state_t;

    state_t      state, state_n;
    logic [31:0] base, base_n, wdata, wdata_n, lanes, lanes_n;
    logic [1:0]  last, last_n;
    logic [2:0]  cnt, cnt_n;
    logic        zext, zext_n, io_req, io_req_n;
    logic [31:0] mem_a_q, mem_a_n, inst_res_q, inst_res_n, data_res_q, data_res_n;
    logic [7:0]  dout_q, dout_n, io_wait, io_wait_n;
    logic        wr_q, wr_n, inst_ready_q, inst_ready_n, data_ready_q, data_ready_n;

    logic [2:0]  e, n;
    logic [1:0]  k, lane;
    logic [31:0] beat;
    logic        complete;

    function automatic logic is_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    function automatic logic [1:0] size_last(input logic [1:0] t);
        case (t)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] l,
                                           input logic z);
        case (l)
            2'd0:    return z ? {24'd0, w[7:0]}   : {{24{w[7]}}, w[7:0]};
            2'd1:    return z ? {16'd0, w[15:0]}  : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            base         <= '0;
            wdata        <= '0;
            lanes        <= '0;
            last         <= '0;
            cnt          <= '0;
            zext         <= 1'b0;
            io_req       <= 1'b0;
            mem_a_q      <= '0;
            dout_q       <= '0;
            wr_q         <= 1'b0;
            io_wait      <= '0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            inst_res_q   <= '0;
            data_res_q   <= '0;
        end else if (rdy) begin
            state        <= state_n;
            base         <= base_n;
            wdata        <= wdata_n;
            lanes        <= lanes_n;
            last         <= last_n;
            cnt          <= cnt_n;
            zext         <= zext_n;
            io_req       <= io_req_n;
            mem_a_q      <= mem_a_n;
            dout_q       <= dout_n;
            wr_q         <= wr_n;
            io_wait      <= io_wait_n;
            inst_ready_q <= inst_ready_n;
            data_ready_q <= data_ready_n;
            inst_res_q   <= inst_res_n;
            data_res_q   <= data_res_n;
        end
    end

    always_comb begin
        state_n      = state;
        base_n       = base;
        wdata_n      = wdata;
        lanes_n      = lanes;
        last_n       = last;
        cnt_n        = cnt;
        zext_n       = zext;
        io_req_n     = io_req;
        mem_a_n      = 32'd0;
        dout_n       = dout_q;
        wr_n         = 1'b0;
        io_wait_n    = (io_wait != 8'd0) ? io_wait - 8'd1 : 8'd0;
        inst_ready_n = 1'b0;
        data_ready_n = 1'b0;
        inst_res_n   = inst_res_q;
        data_res_n   = data_res_q;
        e            = cnt + 3'd1;
        n            = {1'b0, last} + 3'd1;
        lane         = 2'(e - 3'd2);
        complete     = 1'b0;
        k            = 2'd0;
        beat         = 32'd0;

        case (state)
            S_IDLE: begin
                if (bus.data_valid) begin
                    base_n   = bus.data_addr;
                    wdata_n  = bus.data_value;
                    last_n   = size_last(bus.data_type[1:0]);
                    zext_n   = bus.data_type[2];
                    io_req_n = is_io(bus.data_addr);
                    cnt_n    = 3'd0;
                    lanes_n  = 32'd0;
                    if (bus.data_wr) begin
                        state_n = S_STORE;
                        if (!is_io(bus.data_addr) || (!bus.io_buffer_full && io_wait == 8'd0)) begin
                            mem_a_n = bus.data_addr & ADDR_MASK;
                            dout_n  = bus.data_value[7:0];
                            wr_n    = 1'b1;
                            if (is_io(bus.data_addr)) io_wait_n = GAP_LOAD;
                        end
                    end else begin
                        state_n = S_LOAD;
                        mem_a_n = bus.data_addr & ADDR_MASK;
                    end
                end else if (bus.inst_valid && !clear) begin
                    state_n  = S_INST;
                    base_n   = bus.inst_addr;
                    last_n   = 2'd3;
                    io_req_n = 1'b0;
                    cnt_n    = 3'd0;
                    lanes_n  = 32'd0;
                    mem_a_n  = bus.inst_addr & ADDR_MASK;
                end
            end
            S_INST, S_LOAD: begin
                cnt_n = e;
                if (e < n) mem_a_n = (base + 32'(e)) & ADDR_MASK;
                // mem_din lags its address by one cycle, so byte e-2 arrives now
                if (e >= 3'd2) lanes_n[{lane, 3'b000} +: 8] = bus.mem_din;
                if (e == n + 3'd1) begin
                    complete = 1'b1;
                    state_n  = S_IDLE;
                    mem_a_n  = 32'd0;
                    if (state == S_INST) begin
                        inst_res_n   = lanes_n;
                        inst_ready_n = 1'b1;
                    end else begin
                        data_res_n   = extend(lanes_n, last, zext);
                        data_ready_n = 1'b1;
                    end
                end
                // IO reads have side effects, so only fetches and RAM loads are abortable
                if (clear && (state == S_INST || (!io_req && !complete))) begin
                    state_n      = S_IDLE;
                    mem_a_n      = 32'd0;
                    inst_ready_n = 1'b0;
                    inst_res_n   = inst_res_q;
                end
            end
            S_STORE: begin
                if (wr_q && cnt[1:0] == last) begin
                    state_n      = S_IDLE;
                    data_ready_n = 1'b1;
                end else begin
                    k     = wr_q ? cnt[1:0] + 2'd1 : cnt[1:0];
                    cnt_n = {1'b0, k};
                    beat  = base + 32'(k);
                    if (!is_io(beat) || (!bus.io_buffer_full && io_wait == 8'd0)) begin
                        mem_a_n = beat & ADDR_MASK;
                        dout_n  = wdata[{k, 3'b000} +: 8];
                        wr_n    = 1'b1;
                        if (is_io(beat)) io_wait_n = GAP_LOAD;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.mem_a      = mem_a_q;
    assign bus.mem_dout   = dout_q;
    assign bus.mem_wr     = wr_q & rdy;
    assign bus.inst_ready = inst_ready_q;
    assign bus.inst_res   = inst_res_q;
    assign bus.data_ready = data_ready_q;
    assign bus.data_res   = data_res_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a small byte RAM model that, like the real RAM,
// answers one cycle after its address and is frozen together with the core by rdy.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst, rdy, clear;
    int   checks = 0;
    int   failures = 0;
    int   lat;
    logic seen;

    logic        pl_we = 1'b0;
    logic [17:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    logic [7:0]  ram [0:262143];

    mem_ctrl_if bus ();

    mem_ctrl #(.ADDR_BITS(18), .IO_GAP(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        else if (rdy) begin
            if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
            bus.mem_din <= ram[bus.mem_a[17:0]];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_we = 1'b0;
    endtask

    // Returns the accept-relative edge on which data_ready pulses, or -1 on timeout.
    task automatic data_req(input logic wr, input logic [2:0] typ, input logic [31:0] addr,
                            input logic [31:0] val, output int l);
        bus.data_valid = 1'b1; bus.data_wr = wr; bus.data_type = typ;
        bus.data_addr = addr; bus.data_value = val;
        l = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.data_ready === 1'b1) begin l = i; break; end
        end
        bus.data_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        bus.inst_valid = 1'b0; bus.inst_addr = '0;
        bus.data_valid = 1'b0; bus.data_wr = 1'b0; bus.data_type = '0;
        bus.data_addr = '0; bus.data_value = '0; bus.io_buffer_full = 1'b0;

        poke(18'h100, 8'h78); poke(18'h101, 8'h56); poke(18'h102, 8'h34); poke(18'h103, 8'h12);
        poke(18'h200, 8'h80); poke(18'h202, 8'h00); poke(18'h203, 8'h80);
        step();
        check("rst_inst_ready", 32'(bus.inst_ready), 32'd0);
        check("rst_data_ready", 32'(bus.data_ready), 32'd0);
        check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("rst_mem_a", bus.mem_a, 32'd0);
        check("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
        check("rst_inst_res", bus.inst_res, 32'd0);
        check("rst_data_res", bus.data_res, 32'd0);
        rst = 1'b0;
        step();

        data_req(1'b0, 3'd2, 32'h100, 32'd0, lat);
        check("lw_latency", 32'(lat), 32'd5);
        check("lw_res", bus.data_res, 32'h1234_5678);
        step();
        check("lw_single_pulse", 32'(bus.data_ready), 32'd0);
        check("lw_res_hold", bus.data_res, 32'h1234_5678);

        data_req(1'b0, 3'd0, 32'h200, 32'd0, lat);
        check("lb_latency", 32'(lat), 32'd2);
        check("lb_res", bus.data_res, 32'hFFFF_FF80);
        step();
        data_req(1'b0, 3'd4, 32'h200, 32'd0, lat);
        check("lbu_latency", 32'(lat), 32'd2);
        check("lbu_res", bus.data_res, 32'h0000_0080);
        step();
        data_req(1'b0, 3'd1, 32'h202, 32'd0, lat);
        check("lh_latency", 32'(lat), 32'd3);
        check("lh_res", bus.data_res, 32'hFFFF_8000);
        step();
        data_req(1'b0, 3'd5, 32'h202, 32'd0, lat);
        check("lhu_res", bus.data_res, 32'h0000_8000);
        step();

        // data and fetch requested together: store first, fetch afterwards
        bus.inst_valid = 1'b1; bus.inst_addr = 32'h100;
        bus.data_valid = 1'b1; bus.data_wr = 1'b1; bus.data_type = 3'd1;
        bus.data_addr = 32'h10; bus.data_value = 32'h0000_BEEF;
        step();
        check("sh_b0_wr", 32'(bus.mem_wr), 32'd1);
        check("sh_b0_a", bus.mem_a, 32'h10);
        check("sh_b0_d", 32'(bus.mem_dout), 32'hEF);
        step();
        check("sh_b1_wr", 32'(bus.mem_wr), 32'd1);
        check("sh_b1_a", bus.mem_a, 32'h11);
        check("sh_b1_d", 32'(bus.mem_dout), 32'hBE);
        check("sh_not_ready_yet", 32'(bus.data_ready), 32'd0);
        step();
        check("sh_ready_edge2", 32'(bus.data_ready), 32'd1);
        check("sh_wr_off", 32'(bus.mem_wr), 32'd0);
        bus.data_valid = 1'b0;
        lat = -1;
        for (int i = 3; i < 40; i++) begin
            step();
            if (bus.inst_ready === 1'b1) begin lat = i; break; end
        end
        bus.inst_valid = 1'b0;
        check("fetch_after_sh_edge", 32'(lat), 32'd8);
        check("fetch_res", bus.inst_res, 32'h1234_5678);
        check("sh_ram", {24'd0, ram[18'h11], ram[18'h10]}, 32'h0000_BEEF);
        step();

        // IO store held off by a full UART buffer
        bus.io_buffer_full = 1'b1;
        bus.data_valid = 1'b1; bus.data_wr = 1'b1; bus.data_type = 3'd0;
        bus.data_addr = 32'h3_0000; bus.data_value = 32'h41;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.mem_wr !== 1'b0) seen = 1'b1;
        end
        check("io_full_no_wr", 32'(seen), 32'd0);
        bus.io_buffer_full = 1'b0;
        step();
        check("io_release_wr", 32'(bus.mem_wr), 32'd1);
        check("io_release_a", bus.mem_a, 32'h3_0000);
        check("io_release_d", 32'(bus.mem_dout), 32'h41);
        step();
        check("io_sb_ready", 32'(bus.data_ready), 32'd1);
        bus.data_addr = 32'h3_0010; bus.data_value = 32'h2211; bus.data_type = 3'd1;
        step();
        check("io_gap_b0_wr", 32'(bus.mem_wr), 32'd1);
        check("io_gap_b0_d", 32'(bus.mem_dout), 32'h11);
        step();
        check("io_gap_stall", 32'(bus.mem_wr), 32'd0);
        step();
        check("io_gap_b1_wr", 32'(bus.mem_wr), 32'd1);
        check("io_gap_b1_a", bus.mem_a, 32'h3_0011);
        check("io_gap_b1_d", 32'(bus.mem_dout), 32'h22);
        step();
        check("io_sh_ready", 32'(bus.data_ready), 32'd1);
        bus.data_valid = 1'b0;
        step();

        // fetch aborted by clear at edge 2
        bus.inst_valid = 1'b1; bus.inst_addr = 32'h100;
        step(); step();
        clear = 1'b1;
        step();
        clear = 1'b0; bus.inst_valid = 1'b0;
        check("clr_inst_a", bus.mem_a, 32'd0);
        seen = bus.inst_ready;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.inst_ready !== 1'b0) seen = 1'b1;
        end
        check("clr_inst_no_ready", 32'(seen), 32'd0);

        // clear in IDLE blocks fetch acceptance for that edge only
        bus.inst_valid = 1'b1; bus.inst_addr = 32'h100; clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_idle_no_accept", bus.mem_a, 32'd0);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.inst_ready === 1'b1) begin lat = i; break; end
        end
        bus.inst_valid = 1'b0;
        check("clr_idle_then_fetch", 32'(lat), 32'd5);
        step();

        // RAM load aborted by clear
        bus.data_valid = 1'b1; bus.data_wr = 1'b0; bus.data_type = 3'd2; bus.data_addr = 32'h100;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0; bus.data_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.data_ready !== 1'b0) seen = 1'b1;
        end
        check("clr_load_no_ready", 32'(seen), 32'd0);

        // store survives clear
        bus.data_valid = 1'b1; bus.data_wr = 1'b1; bus.data_type = 3'd2;
        bus.data_addr = 32'h40; bus.data_value = 32'hCAFE_BABE;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        lat = -1;
        for (int i = 2; i < 40; i++) begin
            step();
            if (bus.data_ready === 1'b1) begin lat = i; break; end
        end
        bus.data_valid = 1'b0;
        check("clr_sw_ready_edge", 32'(lat), 32'd4);
        check("clr_sw_ram", {ram[18'h43], ram[18'h42], ram[18'h41], ram[18'h40]}, 32'hCAFE_BABE);
        step();

        // rdy low for 3 cycles mid word load
        bus.data_valid = 1'b1; bus.data_wr = 1'b0; bus.data_type = 3'd2; bus.data_addr = 32'h100;
        step();
        check("rdy_a0", bus.mem_a, 32'h100);
        step();
        check("rdy_a1", bus.mem_a, 32'h101);
        rdy = 1'b0;
        step(); step(); step();
        check("rdy_frozen_a", bus.mem_a, 32'h101);
        check("rdy_frozen_wr", 32'(bus.mem_wr), 32'd0);
        rdy = 1'b1;
        lat = -1;
        for (int i = 5; i < 40; i++) begin
            step();
            if (bus.data_ready === 1'b1) begin lat = i; break; end
        end
        bus.data_valid = 1'b0;
        check("rdy_ready_late", 32'(lat), 32'd8);
        check("rdy_res", bus.data_res, 32'h1234_5678);
        step();

        // rdy low during a store beat masks mem_wr immediately
        bus.data_valid = 1'b1; bus.data_wr = 1'b1; bus.data_type = 3'd0;
        bus.data_addr = 32'h50; bus.data_value = 32'h5A;
        step();
        check("rdy_sb_wr", 32'(bus.mem_wr), 32'd1);
        rdy = 1'b0;
        #1;
        check("rdy_sb_wr_masked", 32'(bus.mem_wr), 32'd0);
        step(); step();
        rdy = 1'b1;
        #1;
        check("rdy_sb_wr_back", 32'(bus.mem_wr), 32'd1);
        step();
        check("rdy_sb_ready", 32'(bus.data_ready), 32'd1);
        bus.data_valid = 1'b0;
        step();
        check("rdy_sb_ram", 32'(ram[18'h50]), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
